// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package systolic_pkg;

  localparam int ROW_DIM  = 8;
  localparam int ROW_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    COMPUTE,
    READ_C,
    DONE
  } state_t;

  typedef logic signed [ROW_BITS-1:0] row_t [ROW_DIM];

  // Skewed wavefront: DIM cycles to fill, DIM-1 to drain, DIM-1 for the last products.
  function automatic int compute_cycles(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic logic [ROW_DIM*ROW_BITS-1:0] pack_row(input row_t r);
    logic [ROW_DIM*ROW_BITS-1:0] d;
    d = '0;
    for (int k = 0; k < ROW_DIM; k++) begin
      d[k*ROW_BITS +: ROW_BITS] = r[k];
    end
    return d;
  endfunction

  function automatic row_t unpack_row(input logic [ROW_DIM*ROW_BITS-1:0] d);
    row_t r;
    for (int k = 0; k < ROW_DIM; k++) begin
      r[k] = $signed(d[k*ROW_BITS +: ROW_BITS]);
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host row stream and C-row readout handshake bundle for the sequencer.
// Latency: n/a (wires only).
// Backpressure: host side valid/ready; consumer side c_valid/c_ready.
interface systolic_seq_ctrl_if #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
);
  localparam int RW = $clog2(DIM);

  logic                   host_valid;
  logic                   host_ready;
  logic [DIM*BITS_AB-1:0] host_data;
  logic                   c_valid;
  logic                   c_ready;
  logic [RW-1:0]          mac_crow;

  // Host/DMA and C consumer side.
  modport master (
    output host_valid, host_data, c_ready,
    input  host_ready, c_valid, mac_crow
  );

  // Sequencer side.
  modport slave (
    input  host_valid, host_data, c_ready,
    output host_ready, c_valid, mac_crow
  );

endinterface

// File: rtl/seq_counter.sv
// Up/down row/cycle counter with clear, increment and fixed terminal compare.
// Latency: count updates one cycle after inc; at_term is combinational on the count.
// Backpressure: none; holds its value whenever inc is low.
module seq_counter #(
  parameter int          W    = 3,
  parameter int unsigned INIT = 0,
  parameter int unsigned TERM = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         down,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  localparam logic [W-1:0] INIT_V = W'(INIT);
  localparam logic [W-1:0] TERM_V = W'(TERM);

  assign at_term = (cnt == TERM_V);

  // Step toward TERM; stepping from TERM reloads INIT explicitly instead of relying on wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= INIT_V;
    end else if (inc) begin
      if (at_term) begin
        cnt <= INIT_V;
      end else if (down) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one DIMxDIM multiply: load A rows, load B rows, run the skewed window, read C rows.
// Latency: unstalled, start in cycle 0 gives done in cycle 2*DIM + (3*DIM-2) + DIM + 1.
// Backpressure: host rows stall on host_valid low; C readout stalls indefinitely on c_ready low.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  systolic_seq_ctrl_if.slave        bus,
  output logic [$clog2(DIM)-1:0]    b_row_idx,
  output logic                      memA_en,
  output logic                      memA_wren,
  output logic [$clog2(DIM)-1:0]    memA_row,
  output logic signed [BITS_AB-1:0] memA_din [DIM],
  output logic                      memB_en,
  output logic signed [BITS_AB-1:0] memB_din [DIM],
  output logic                      mac_en,
  output logic                      mac_clr
);

  localparam int          RW       = $clog2(DIM);
  localparam int          CW       = $clog2(3 * DIM);
  localparam int unsigned CYC_LAST = 32'(compute_cycles(DIM) - 1);

  // The accumulators must at least hold one full-width product.
  if (BITS_C < 2 * BITS_AB) begin : g_bits_c_chk
    $error("BITS_C is too narrow for BITS_AB x BITS_AB products");
  end

  state_t        state_q, state_d;
  logic          mac_clr_q;
  logic [RW-1:0] a_cnt, b_cnt, c_cnt;
  logic [CW-1:0] cyc_cnt;
  logic          a_last, b_last, cyc_last, c_last;
  logic          in_idle, a_beat, b_beat, c_accept;
  logic          host_ready_w, c_valid_w;
  logic [RW-1:0] mac_crow_w;
  logic          unused_cyc_cnt;

  assign in_idle  = (state_q == IDLE);
  assign a_beat   = (state_q == LOAD_A) && bus.host_valid;
  assign b_beat   = (state_q == LOAD_B) && bus.host_valid;
  assign c_accept = (state_q == READ_C) && bus.c_ready;

  // The window length is only needed through its terminal flag.
  assign unused_cyc_cnt = ^cyc_cnt;

  seq_counter #(.W(RW), .INIT(0), .TERM(DIM - 1)) u_a_cnt (
    .clk(clk), .rst(rst), .clr(in_idle), .inc(a_beat), .down(1'b0),
    .cnt(a_cnt), .at_term(a_last)
  );

  // B arrives last-row-first, so this one counts down.
  seq_counter #(.W(RW), .INIT(DIM - 1), .TERM(0)) u_b_cnt (
    .clk(clk), .rst(rst), .clr(in_idle), .inc(b_beat), .down(1'b1),
    .cnt(b_cnt), .at_term(b_last)
  );

  seq_counter #(.W(CW), .INIT(0), .TERM(CYC_LAST)) u_cyc_cnt (
    .clk(clk), .rst(rst), .clr(in_idle), .inc(state_q == COMPUTE), .down(1'b0),
    .cnt(cyc_cnt), .at_term(cyc_last)
  );

  seq_counter #(.W(RW), .INIT(0), .TERM(DIM - 1)) u_c_cnt (
    .clk(clk), .rst(rst), .clr(in_idle), .inc(c_accept), .down(1'b0),
    .cnt(c_cnt), .at_term(c_last)
  );

  // State register plus the accumulator clear, which lands on the first LOAD_A cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_clr_q <= in_idle && start;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    host_ready_w = 1'b0;
    memA_en      = 1'b0;
    memA_wren    = 1'b0;
    memA_row     = '0;
    memB_en      = 1'b0;
    mac_en       = 1'b0;
    c_valid_w    = 1'b0;
    mac_crow_w   = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        busy         = 1'b1;
        host_ready_w = 1'b1;
        memA_wren    = bus.host_valid;
        memA_row     = a_cnt;
        if (a_beat && a_last) state_d = LOAD_B;
      end
      LOAD_B: begin
        busy         = 1'b1;
        host_ready_w = 1'b1;
        memB_en      = bus.host_valid;
        if (b_beat && b_last) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy    = 1'b1;
        memA_en = 1'b1;
        memB_en = 1'b1;
        mac_en  = 1'b1;
        if (cyc_last) state_d = READ_C;
      end
      READ_C: begin
        busy       = 1'b1;
        c_valid_w  = 1'b1;
        mac_crow_w = c_cnt;
        if (c_accept && c_last) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Host row fans straight out to whichever memory is loading; zeros otherwise, which also
  // feeds the zero skew fill into memB during COMPUTE.
  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      memA_din[k] = '0;
      memB_din[k] = '0;
      if (state_q == LOAD_A) memA_din[k] = $signed(bus.host_data[k*BITS_AB +: BITS_AB]);
      if (state_q == LOAD_B) memB_din[k] = $signed(bus.host_data[k*BITS_AB +: BITS_AB]);
    end
  end

  assign b_row_idx      = b_cnt;
  assign mac_clr        = mac_clr_q;
  assign bus.host_ready = host_ready_w;
  assign bus.c_valid    = c_valid_w;
  assign bus.mac_crow   = mac_crow_w;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for the systolic sequencer: cycle table for an unstalled job plus gap,
// stall, ignored-start and mid-job-reset jobs, with a C scoreboard built from captured rows.
// Backpressure: the bench plays both host (host_valid gaps) and consumer (c_ready stalls).
module tb_systolic_seq_ctrl;
  import systolic_pkg::*;

  localparam int DIM     = 8;
  localparam int BITS_AB = 8;
  localparam int BITS_C  = 16;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic [2:0] b_row_idx, memA_row;
  logic memA_en, memA_wren, memB_en, mac_en, mac_clr;
  logic signed [BITS_AB-1:0] memA_din [DIM];
  logic signed [BITS_AB-1:0] memB_din [DIM];

  systolic_seq_ctrl_if #(.DIM(DIM), .BITS_AB(BITS_AB)) bus ();

  systolic_seq_ctrl #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus),
    .b_row_idx(b_row_idx), .memA_en(memA_en), .memA_wren(memA_wren),
    .memA_row(memA_row), .memA_din(memA_din), .memB_en(memB_en),
    .memB_din(memB_din), .mac_en(mac_en), .mac_clr(mac_clr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  row_t amat [DIM];
  row_t bmat [DIM];
  row_t a_cap [DIM];
  row_t b_cap [DIM];
  row_t junk;

  typedef struct {
    int          cyc;
    bit          start;
    bit          hv;
    bit          cr;
    logic [17:0] vec;
  } vec_t;
  vec_t tab [13];

  function automatic logic [17:0] mk(input bit bsy, dn, hr, wr, aen, ben, mac, clr, cv,
                                     input int row, bidx, crow);
    return {bsy, dn, hr, wr, aen, ben, mac, clr, cv, 3'(row), 3'(bidx), 3'(crow)};
  endfunction

  function automatic logic [17:0] outs();
    return {busy, done, bus.host_ready, memA_wren, memA_en, memB_en, mac_en, mac_clr,
            bus.c_valid, memA_row, b_row_idx, bus.mac_crow};
  endfunction

  function automatic bit any_nz();
    bit nz = 1'b0;
    for (int k = 0; k < DIM; k++) nz |= (memA_din[k] != 0) || (memB_din[k] != 0);
    return nz;
  endfunction

  task automatic check(input string name, input int t, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, t, act, exp);
    end
  endtask

  task automatic init_mats(input int seed);
    for (int i = 0; i < DIM; i++) begin
      for (int k = 0; k < DIM; k++) begin
        amat[i][k]  = 8'((i * 3 - k * 5 + seed * 7) % 50);
        bmat[i][k]  = 8'((i * k - 11 + k + seed * 3) % 60);
        a_cap[i][k] = '0;
        b_cap[i][k] = '0;
      end
    end
  endtask

  // One job from the start pulse (cycle 0) onward, sampled at the falling edge of each cycle.
  task automatic run_job(input string tag, input bit gap, input int stall_at, input int stall_len,
                         input bit pokes, input int rst_at, input int exp_done, input bit use_tab);
    int a_beats = 0, b_beats = 0, c_exp = 0, done_cyc = -1, done_cnt = 0;
    int mac_cnt = 0, mac_first = -1, mac_last = -1, clr_cnt = 0, clr_cyc = -1;
    int wren_cnt = 0, spur = 0, t;
    bit fin = 1'b0;
    bit in_stall;
    for (t = 0; t <= 160 && !fin; t++) begin
      @(posedge clk);
      #1;
      in_stall      = (stall_len > 0) && (t >= stall_at) && (t < stall_at + stall_len);
      start         = (t == 0) || (pokes && (t == 25 || t == exp_done));
      bus.host_valid = gap ? (t % 2 == 0) : 1'b1;
      bus.c_ready   = !in_stall;
      rst           = (t == rst_at);
      if (a_beats < DIM)      bus.host_data = pack_row(amat[a_beats]);
      else if (b_beats < DIM) bus.host_data = pack_row(bmat[DIM-1-b_beats]);
      else                    bus.host_data = pack_row(junk);
      if (use_tab) begin
        foreach (tab[e]) begin
          if (tab[e].cyc == t) begin
            start = tab[e].start; bus.host_valid = tab[e].hv; bus.c_ready = tab[e].cr;
          end
        end
      end
      @(negedge clk);
      if (memA_wren) begin
        wren_cnt++;
        check({tag, ":memA_row"}, t, memA_row, a_beats);
        a_cap[memA_row] = memA_din;
      end
      if (bus.host_ready && memB_en) begin
        check({tag, ":b_row_idx"}, t, b_row_idx, DIM - 1 - b_beats);
        b_cap[b_row_idx] = memB_din;
      end
      if (!bus.host_valid && (memA_wren || (memB_en && !mac_en))) spur++;
      if (bus.host_valid && bus.host_ready) begin
        if (a_beats < DIM) a_beats++; else b_beats++;
      end
      if (mac_en) begin
        mac_cnt++;
        if (mac_first < 0) mac_first = t;
        mac_last = t;
        check({tag, ":compute_en"}, t, {memA_en, memB_en, any_nz()}, 3'b110);
      end
      if (mac_clr) begin clr_cnt++; clr_cyc = t; end
      if (in_stall) check({tag, ":cvalid_stall"}, t, bus.c_valid, 1);
      if (bus.c_valid && !bus.c_ready) check({tag, ":crow_hold"}, t, bus.mac_crow, c_exp);
      if (bus.c_valid && bus.c_ready) begin
        check({tag, ":mac_crow"}, t, bus.mac_crow, c_exp);
        for (int j = 0; j < DIM; j++) begin
          int got = 0, want = 0, x, y;
          for (int k = 0; k < DIM; k++) begin
            x = a_cap[bus.mac_crow][k]; y = b_cap[k][j]; got += x * y;
            x = amat[c_exp][k];        y = bmat[k][j];  want += x * y;
          end
          check({tag, ":c_elem"}, t, got, want);
        end
        c_exp++;
      end
      if (done) begin done_cnt++; done_cyc = t; end
      if (done_cyc >= 0 && t > done_cyc) check({tag, ":idle_after_done"}, t, busy, 0);
      if (use_tab) begin
        foreach (tab[e]) if (tab[e].cyc == t) check({tag, ":tab_vec"}, t, outs(), tab[e].vec);
      end
      if (rst_at >= 0 && t == rst_at + 1)
        check({tag, ":rst_abort_idle"}, t, {outs(), any_nz()}, {mk(0,0,0,0,0,0,0,0,0, 0,7,0), 1'b0});
      if (rst_at >= 0 && t > rst_at) check({tag, ":rst_no_done"}, t, {busy, done}, 2'b00);
      if (rst_at >= 0) fin = (t >= rst_at + 4);
      else             fin = (done_cyc >= 0) && (t >= done_cyc + 2);
    end
    if (!fin) check({tag, ":job_finished"}, t, 0, 1);
    if (rst_at < 0) begin
      check({tag, ":done_count"}, t, done_cnt, 1);
      check({tag, ":done_cycle"}, t, done_cyc, exp_done);
      check({tag, ":mac_en_count"}, t, mac_cnt, 3 * DIM - 2);
      check({tag, ":mac_en_span"}, t, mac_last - mac_first, 3 * DIM - 3);
      check({tag, ":mac_clr_count"}, t, clr_cnt, 1);
      check({tag, ":mac_clr_cycle"}, t, clr_cyc, 1);
      check({tag, ":wren_count"}, t, wren_cnt, DIM);
      check({tag, ":spurious_writes"}, t, spur, 0);
      check({tag, ":c_rows_read"}, t, c_exp, DIM);
      check({tag, ":b_rows_sent"}, t, b_beats, DIM);
    end else begin
      check({tag, ":done_count"}, t, done_cnt, 0);
    end
    @(posedge clk);
    #1;
    start = 1'b0; rst = 1'b0; bus.host_valid = 1'b0; bus.c_ready = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < DIM; k++) junk[k] = 8'sh5A;
    tab[0]  = '{0,  1'b1, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0, 0,7,0)};
    tab[1]  = '{1,  1'b0, 1'b1, 1'b1, mk(1,0,1,1,0,0,0,1,0, 0,7,0)};
    tab[2]  = '{2,  1'b0, 1'b1, 1'b1, mk(1,0,1,1,0,0,0,0,0, 1,7,0)};
    tab[3]  = '{8,  1'b0, 1'b1, 1'b1, mk(1,0,1,1,0,0,0,0,0, 7,7,0)};
    tab[4]  = '{9,  1'b0, 1'b1, 1'b1, mk(1,0,1,0,0,1,0,0,0, 0,7,0)};
    tab[5]  = '{16, 1'b0, 1'b1, 1'b1, mk(1,0,1,0,0,1,0,0,0, 0,0,0)};
    tab[6]  = '{17, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,1,1,1,0,0, 0,7,0)};
    tab[7]  = '{38, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,1,1,1,0,0, 0,7,0)};
    tab[8]  = '{39, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,1, 0,7,0)};
    tab[9]  = '{42, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,1, 0,7,3)};
    tab[10] = '{46, 1'b0, 1'b1, 1'b1, mk(1,0,0,0,0,0,0,0,1, 0,7,7)};
    tab[11] = '{47, 1'b0, 1'b1, 1'b1, mk(1,1,0,0,0,0,0,0,0, 0,7,0)};
    tab[12] = '{48, 1'b0, 1'b1, 1'b1, mk(0,0,0,0,0,0,0,0,0, 0,7,0)};

    rst = 1'b1; start = 1'b0; bus.host_valid = 1'b0; bus.c_ready = 1'b1; bus.host_data = '0;
    init_mats(0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_vec", 0, {outs(), any_nz()}, {mk(0,0,0,0,0,0,0,0,0, 0,7,0), 1'b0});
    // Host rows offered while idle must be ignored.
    @(posedge clk);
    #1 bus.host_valid = 1'b1; bus.host_data = pack_row(amat[1]);
    repeat (2) begin
      @(negedge clk);
      check("idle_host_valid", 0, {outs(), any_nz()}, {mk(0,0,0,0,0,0,0,0,0, 0,7,0), 1'b0});
    end
    @(posedge clk);
    #1 bus.host_valid = 1'b0;

    init_mats(1); run_job("nostall",  1'b0, -1, 0, 1'b0, -1, 47, 1'b1);
    init_mats(2); run_job("hostgap",  1'b1, -1, 0, 1'b0, -1, 63, 1'b0);
    init_mats(3); run_job("c_stall",  1'b0, 42, 5, 1'b0, -1, 52, 1'b0);
    init_mats(4); run_job("ign_start", 1'b0, -1, 0, 1'b1, -1, 47, 1'b0);
    init_mats(5); run_job("mid_rst",  1'b0, -1, 0, 1'b0, 20, -1, 1'b0);
    init_mats(6); run_job("post_rst", 1'b0, -1, 0, 1'b0, -1, 47, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=0 got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Top-level sequencer for one DIMxDIM matrix multiply.
- Streams A rows into memA over a valid/ready host port, then B rows into memB over the same port.
- Runs the skewed compute window with memA, memB and the MAC array enabled, then steps C rows out to a consumer with backpressure.
- Sits between the host/DMA stream and the memA/memB/systolic-array datapath.

Parameters:
- BITS_AB, 8, width of A/B elements (signed)
- BITS_C, 16, width of C accumulators (sizes nothing here; kept for parameter symmetry)
- DIM, 8, array dimension; rows per matrix

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on job completion
- host_valid  in  1  host row valid
- host_ready  out  1  controller accepts host row
- host_data  in  DIM*BITS_AB  packed row; element k at [k*BITS_AB +: BITS_AB]
- b_row_idx  out  $clog2(DIM)  B row index expected next (DIM-1 down to 0)
- memA_en  out  1  memA shift enable
- memA_wren  out  1  memA row write enable
- memA_row  out  $clog2(DIM)  memA write row
- memA_din  out  DIM x BITS_AB  unpacked A row to memA
- memB_en  out  1  memB shift enable
- memB_din  out  DIM x BITS_AB  unpacked B row to memB
- mac_en  out  1  systolic array enable
- mac_clr  out  1  one-cycle accumulator clear
- mac_crow  out  $clog2(DIM)  C row select for readout
- c_valid  out  1  C row selected by mac_crow is valid
- c_ready  in  1  consumer accepts the C row

Behaviour:
- Reset: state IDLE, all counters 0, and every output is 0 except b_row_idx = DIM-1. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, READ_C, DONE.
- Handshake: a beat fires when host_valid && host_ready. host_ready = 1 only in LOAD_A and LOAD_B.
- IDLE:
  - start moves to LOAD_A.
  - mac_clr is registered high for exactly the first LOAD_A cycle.
  - All counters clear.
- LOAD_A:
  - memA_wren = host_valid.
  - memA_row = a_cnt.
  - memA_din = unpacked host_data.
  - memA_en = 0.
  - a_cnt increments per beat.
  - On the beat with a_cnt == DIM-1, go to LOAD_B.
- LOAD_B:
  - memB_en = host_valid; memB_din = unpacked host_data; memA_en = 0.
  - b_row_idx starts at DIM-1 and decrements per beat.
  - Host sends B rows in order DIM-1..0.
  - On the beat with b_row_idx == 0, go to COMPUTE.
- COMPUTE:
  - memA_en = memB_en = mac_en = 1; memB_din = 0.
  - cyc_cnt counts 0..3*DIM-3, i.e. exactly 3*DIM-2 cycles (22 for DIM=8), then go to READ_C.
- READ_C:
  - c_valid = 1; mac_crow = c_cnt.
  - c_cnt advances only on c_valid && c_ready.
  - Accept at c_cnt == DIM-1 goes to DONE.
  - Stalls indefinitely without c_ready; mac_crow stays stable while stalled.
- DONE: done = 1 for one cycle, busy = 1; next state IDLE. start in DONE is ignored.
- start while busy is ignored, with no queuing.
- host_valid outside LOAD_A/LOAD_B: no write, no shift, no state change.
- host_valid low mid-load: the counter holds and memA_wren/memB_en are 0 that cycle.
- Data paths are combinational pass-through; only state and counters are registered.
- Counter widths:
  - a_cnt, b_row_idx, c_cnt are $clog2(DIM) bits.
  - cyc_cnt is $clog2(3*DIM) bits.
  - Terminal comparisons are explicit, not wrap-based.
- Unstalled latency (host_valid and c_ready tied high): start sampled in cycle 0 gives the following schedule.
  - LOAD_A: cycles 1-8
  - LOAD_B: cycles 9-16
  - COMPUTE: cycles 17-38
  - READ_C: cycles 39-46
  - done: cycle 47

Decomposition:
- Package systolic_pkg:
  - state enum typedef.
  - Row typedef as a DIM x BITS_AB signed unpacked array.
  - Function compute_cycles(DIM) = 3*DIM-2.
  - Function pack/unpack helpers between host_data and the row type.
- Sub-module seq_counter: parameterised width, with clr, inc, up/down select and terminal-value compare.
  - One instance each for a_cnt, b_row_idx (down), cyc_cnt and c_cnt.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release -> all outputs 0, b_row_idx = 7, host_ready = 0; start = 0 keeps busy = 0.
- Full job, no stalls (DIM=8):
  - Stimulus: start pulse; A rows A[0..7]; B rows B[7..0]; c_ready = 1.
  - memA_row goes 0..7 with memA_wren high in cycles 1-8.
  - mac_clr is high only in cycle 1.
  - mac_en is high in exactly cycles 17-38.
  - mac_crow goes 0..7 in cycles 39-46; done is high in cycle 47 only.
  - Scoreboard the C read against software A*B.
- Host gaps: drop host_valid every other cycle during both loads -> counters hold on gaps, no spurious memA_wren/memB_en, done at cycle 63.
- Consumer backpressure: c_ready low for 5 cycles at c_cnt = 3 -> mac_crow holds at 3, c_valid stays high, done is delayed by 5 cycles.
- Ignored start: pulse start during COMPUTE and in DONE -> no restart; the next job starts only from IDLE.
- Mid-job reset: assert rst in cycle 20 (COMPUTE) -> next cycle is IDLE with all outputs 0 and no done pulse; a subsequent full job completes correctly.
